// File: rtl/frame_thresh_seq.sv
// Frame sequencer: streams an IMG_W x IMG_H pixel frame through an external threshold
// datapath and writes results back. Optional strong/weak result counters via THRESH_STATS_EN.
module frame_thresh_seq #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_upper,
    input  logic [7:0]        cfg_lower,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        thr_upper,
    output logic [7:0]        thr_lower,
    output logic [7:0]        dp_data,
    output logic              dp_valid,
    input  logic [7:0]        dp_result,
    input  logic              dp_result_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   strong_cnt,
    output logic [ADDR_W:0]   weak_cnt
);
    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic [7:0]        thr_upper_q, thr_upper_d;
    logic [7:0]        thr_lower_q, thr_lower_d;
    logic              dp_valid_q, dp_valid_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] addr_d1_q, addr_d1_d;
    logic [ADDR_W-1:0] addr_d2_q, addr_d2_d;

    // Abort must suppress the read in the very cycle it is asserted.
    assign rd_en = rd_en_q & ~abort;

    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        thr_upper_d = thr_upper_q;
        thr_lower_d = thr_lower_q;
        dp_valid_d  = rd_en;
        wr_vld_d    = dp_valid_q;
        addr_d1_d   = rd_addr_q;
        addr_d2_d   = addr_d1_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_lower <= cfg_upper) begin
                        thr_upper_d = cfg_upper;
                        thr_lower_d = cfg_lower;
                        rd_addr_d   = '0;
                        rd_en_d     = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // drain_d holds the number of extra drain cycles: an aborted cycle issued no read.
                if (abort) begin
                    rd_en_d = 1'b0;
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else if (rd_addr_q == LAST_ADDR) begin
                    rd_en_d = 1'b0;
                    drain_d = 1'b1;
                    state_d = DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (!drain_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    drain_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            thr_upper_q <= 8'd220;
            thr_lower_q <= 8'd85;
            dp_valid_q  <= 1'b0;
            wr_vld_q    <= 1'b0;
            addr_d1_q   <= '0;
            addr_d2_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            thr_upper_q <= thr_upper_d;
            thr_lower_q <= thr_lower_d;
            dp_valid_q  <= dp_valid_d;
            wr_vld_q    <= wr_vld_d;
            addr_d1_q   <= addr_d1_d;
            addr_d2_q   <= addr_d2_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign rd_addr   = rd_addr_q;
    assign thr_upper = thr_upper_q;
    assign thr_lower = thr_lower_q;
    assign dp_valid  = dp_valid_q;
    assign dp_data   = dp_valid_q ? rd_data : 8'd0;
    // Gate with our own pipeline flag so a reset mid-frame kills stale datapath results.
    assign wr_en     = dp_result_valid & wr_vld_q;
    assign wr_addr   = addr_d2_q;
    assign wr_data   = wr_en ? dp_result : 8'd0;

`ifdef THRESH_STATS_EN
    localparam logic [ADDR_W:0] N_CNT = (ADDR_W + 1)'(N);
    logic [ADDR_W:0] strong_q, strong_d;
    logic [ADDR_W:0] weak_q, weak_d;
    logic            cnt_clr;

    assign cnt_clr = (state_q == IDLE) && start && (cfg_lower <= cfg_upper);

    always_comb begin
        strong_d = strong_q;
        weak_d   = weak_q;
        if (cnt_clr) begin
            strong_d = '0;
            weak_d   = '0;
        end else if (wr_en) begin
            if (wr_data == 8'hFF && strong_q != N_CNT) strong_d = strong_q + (ADDR_W + 1)'(1);
            if (wr_data == 8'h00 && weak_q != N_CNT)   weak_d   = weak_q + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strong_q <= '0;
            weak_q   <= '0;
        end else begin
            strong_q <= strong_d;
            weak_q   <= weak_d;
        end
    end

    assign strong_cnt = strong_q;
    assign weak_cnt   = weak_q;
`else
    assign strong_cnt = '0;
    assign weak_cnt   = '0;
`endif

endmodule

// File: tb/tb_frame_thresh_seq.sv
// Scoreboard bench for frame_thresh_seq on a 4x4 frame with behavioural pixel memory and datapath.
module tb_frame_thresh_seq;
    localparam int IMG_W = 4, IMG_H = 4, ADDR_W = 4, N = IMG_W * IMG_H;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [7:0] cfg_upper = 8'd0, cfg_lower = 8'd0;
    logic busy, done, cfg_err, rd_en, dp_valid, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [7:0] rd_data = 8'd0, dp_result = 8'd0, thr_upper, thr_lower, dp_data, wr_data;
    logic dp_result_valid = 1'b0;
    logic [ADDR_W:0] strong_cnt, weak_cnt;

    frame_thresh_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_upper(cfg_upper), .cfg_lower(cfg_lower),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .thr_upper(thr_upper), .thr_lower(thr_lower),
        .dp_data(dp_data), .dp_valid(dp_valid),
        .dp_result(dp_result), .dp_result_valid(dp_result_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .strong_cnt(strong_cnt), .weak_cnt(weak_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, t0 = 0, rd_idx = 0;
    logic [7:0] mem [N];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        int                cyc;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [7:0] thr_fn(input logic [7:0] x, input logic [7:0] u, input logic [7:0] l);
        if (x > u)      return 8'hFF;
        else if (x < l) return 8'h00;
        else            return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory (one-cycle read latency) and a one-cycle threshold datapath.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
    always @(posedge clk) begin
        dp_result_valid <= dp_valid;
        dp_result       <= thr_fn(dp_data, thr_upper, thr_lower);
    end

    // Monitor: checks the read sequence and pops the scoreboard on every write.
    always @(negedge clk) begin
        if (rd_en) begin
            chk("rd_addr", 32'(rd_addr), 32'(rd_idx));
            rd_idx++;
        end
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0d expected=none", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("wr cyc=%0d addr=%0d data=0x%02h", cyc - t0, wr_addr, wr_data);
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_cycle", 32'(cyc - t0), 32'(e.cyc));
            end
        end
    end

    task automatic push_writes(input logic [7:0] up, input logic [7:0] lo, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = ADDR_W'(i);
            e.data = thr_fn(mem[i], up, lo);
            e.cyc  = i + 3;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [7:0] up, input logic [7:0] lo, input int abort_at,
                             input bit disturb, input int es, input int ew);
        int nreads, busy_cnt, done_rel, rel;
        nreads = (abort_at > 0) ? abort_at - 1 : N;
`ifndef THRESH_STATS_EN
        es = 0;
        ew = 0;
`endif
        push_writes(up, lo, nreads);
        @(posedge clk); #1;
        rd_idx = 0;
        start = 1'b1; cfg_upper = up; cfg_lower = lo; t0 = cyc;
        busy_cnt = 0; done_rel = -1;
        for (int k = 0; k < 60 && done_rel < 0; k++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            if (busy) busy_cnt++;
            if (done) done_rel = rel;
            if (disturb && rel == 8) chk("thr_upper_mid", 32'(thr_upper), 32'(up));
            start     = disturb && rel == 6;
            cfg_upper = (disturb && rel >= 6) ? 8'd10 : up;
            abort     = (rel == abort_at);
        end
        $display("frame up=%0d lo=%0d reads=%0d done_cyc=%0d strong=%0d weak=%0d",
                 up, lo, rd_idx, done_rel, strong_cnt, weak_cnt);
        chk("done_cycle", 32'(done_rel), 32'(nreads + 3));
        chk("busy_cycles", 32'(busy_cnt), 32'(nreads + 2));
        chk("read_count", 32'(rd_idx), 32'(nreads));
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("strong_cnt", 32'(strong_cnt), 32'(es));
        chk("weak_cnt", 32'(weak_cnt), 32'(ew));
        chk("thr_upper", 32'(thr_upper), 32'(up));
        chk("thr_lower", 32'(thr_lower), 32'(lo));
        cfg_upper = up;
        @(posedge clk); #1;
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("strong_hold", 32'(strong_cnt), 32'(es));
        chk("weak_hold", 32'(weak_cnt), 32'(ew));
    endtask

    task automatic check_reset_values(input string tag);
        logic [31:0] agg;
        agg = {16'(0), busy, done, cfg_err, rd_en, dp_valid, wr_en, 10'(0)};
        chk({tag, "_ctrl"}, agg, 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_dp_data"}, 32'(dp_data), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_cnts"}, 32'({strong_cnt, weak_cnt}), 32'd0);
        chk({tag, "_thr_upper"}, 32'(thr_upper), 32'd220);
        chk({tag, "_thr_lower"}, 32'(thr_lower), 32'd85);
    endtask

    initial begin
        int rel, done_seen, busy_seen;
        for (int i = 0; i < N; i++) mem[i] = 8'(i * 15);   // ramp 0..225

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("reset");

        // Nominal frame: >220 only 225, <85 six pixels.
        run_frame(8'd220, 8'd85, -1, 1'b0, 1, 6);

        // Inverted thresholds are rejected with a single cfg_err pulse.
        @(posedge clk); #1;
        rd_idx = 0; start = 1'b1; cfg_upper = 8'd100; cfg_lower = 8'd200; t0 = cyc;
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            if (rel <= 2) chk("cfg_err", 32'(cfg_err), (rel == 1) ? 32'd1 : 32'd0);
            if (busy) busy_seen++;
            if (done) done_seen++;
            start = 1'b0;
        end
        $display("cfg_err test reads=%0d busy=%0d done=%0d", rd_idx, busy_seen, done_seen);
        chk("cfg_err_reads", 32'(rd_idx), 32'd0);
        chk("cfg_err_busy", 32'(busy_seen + done_seen), 32'd0);
        chk("cfg_err_thr_upper", 32'(thr_upper), 32'd220);

        // Abort in cycle 5: reads 0..3 (all below 85, so four weak results).
        run_frame(8'd220, 8'd85, 5, 1'b0, 0, 4);

        // Reset in cycle 8: writes for reads 0..5 land in cycles 3..8, nothing after.
        push_writes(8'd220, 8'd85, 6);
        @(posedge clk); #1;
        rd_idx = 0; start = 1'b1; cfg_upper = 8'd30; cfg_lower = 8'd20; t0 = cyc;
        push_writes(8'd30, 8'd20, 0);
        exp_q.delete();
        push_writes(8'd30, 8'd20, 6);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            start = 1'b0;
            rst = (rel == 8);
        end
        rst = 1'b0;
        check_reset_values("midreset");
        chk("midreset_pending", 32'(exp_q.size()), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        $display("mid-frame reset done_pulses=%0d", done_seen);
        chk("midreset_no_done", 32'(done_seen), 32'd0);
        run_frame(8'd220, 8'd85, -1, 1'b0, 1, 6);

        // Mid-frame start and cfg_upper change must be ignored.
        run_frame(8'd220, 8'd85, -1, 1'b1, 1, 6);

        // Equal thresholds are legal: 135..225 strong (7), 0..120 weak (9).
        run_frame(8'd128, 8'd128, -1, 1'b0, 7, 9);

        repeat (5) @(posedge clk);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
